writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register and writeback formatter; sits directly upstream of the 64-bit, 32-entry register file and drives its wrd/wbd/wwreg inputs.
- Selects between the ALU result, load data (extracted and extended from the raw memory doubleword), and PC+4.
- Merges results from a long-latency unit (divider etc.) through a 2-entry queue; the main pipeline has priority and never stalls.

Parameters:
- XLEN, 64, datapath width
- LQ_DEPTH, 2, long-latency queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; W register updates on posedge (register file writes on negedge of the same cycle)
- clrn  in  1  asynchronous active-low reset
- mvalid  in  1  MEM-stage instruction valid
- mwreg  in  1  MEM instruction writes rd
- mrd  in  5  MEM destination register
- msel  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU
- malu  in  XLEN  ALU result
- mmem  in  XLEN  raw aligned doubleword from data memory
- mfunct3  in  3  load type
- maddr_lo  in  3  byte offset within the doubleword
- mpc4  in  XLEN  PC+4
- lvalid  in  1  long-latency result valid
- lready  out  1  queue can accept
- lrd  in  5  long-latency destination
- ldata  in  XLEN  long-latency result
- wrd  out  5  writeback destination to register file
- wbd  out  XLEN  writeback data to register file
- wwreg  out  1  register file write enable
- pend_mask  out  32  bit n set if any queued or W-stage write targets xn (bit 0 always 0)
- lq_count  out  2  queue occupancy

Behaviour:
- Reset (clrn low, async): W valid=0, wrd=0, wbd=0, wwreg=0, queue empty, lq_count=0, pend_mask=0, lready=0 while clrn low.
- Load extraction, combinational on MEM inputs:
  - funct3 000 LB / 100 LBU: byte at maddr_lo.
  - 001 LH / 101 LHU: half at maddr_lo[2:1].
  - 010 LW / 110 LWU: word at maddr_lo[2].
  - 011 LD: full doubleword, offset ignored.
  - Sign-extend for 000/001/010; zero-extend for 100/101/110; 111 yields 0.
  - Unused offset low bits are ignored; no misalignment trap here.
- W capture priority at each posedge:
  1. mvalid: capture MEM result; write = mwreg.
  2. else queue non-empty: pop head; write = 1.
  3. else lvalid & queue empty: capture lrd/ldata directly (bypass, no push); handshake counts as accepted.
  4. else bubble (W valid=0).
- Push: lvalid & lready & not consumed by bypass → enqueue at tail. Push and pop may occur in the same cycle; count is unchanged.
- lready = clrn & (lq_count < LQ_DEPTH). At full, lready is 0 and lvalid must be held by the source.
- Outputs are registered, valid from the posedge after capture through the next posedge:
  - wrd/wbd hold the W contents.
  - wwreg = Wvalid & Wwrite & (wrd != 0).
  - Bubbles drive wwreg=0; wrd/wbd are held.
- Latency: MEM → register file write = 1 cycle; a long-latency result waits 1 + (cycles blocked by mvalid).
- Ordering: queue is FIFO. No hazard checking between sources; the issue stage uses pend_mask to interlock.
- Reset asserted mid-operation discards queue and W contents; no write is issued.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined: adds outputs stat_wb [31:0] and stat_lblock [31:0], reset to 0, wrapping at 2^32.
  - stat_wb increments per cycle with wwreg=1.
  - stat_lblock increments per cycle with queue non-empty & mvalid.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then mvalid=1, mwreg=1, mrd=5, msel=00, malu=0x1234 → next cycle wwreg=1, wrd=5, wbd=0x1234. mrd=0 → wwreg=0.
- Loads with mmem=0x8877_6655_4433_2211:
  - LB, off=7 → 0xFFFF_FFFF_FFFF_FF88.
  - LBU, off=7 → 0x88.
  - LH, off=2 → 0x4433.
  - LW, off=4 → 0xFFFF_FFFF_8877_6655.
  - LWU, off=4 → 0x8877_6655.
  - LD → full value.
- msel=10, mpc4=0x1004, mrd=1 → wbd=0x1004, wrd=1.
- lvalid with rd 7/8/9 while mvalid held 1 for 4 cycles:
  - lready drops after 2 accepts; rd 9 is held.
  - pend_mask bits 7 and 8 are set.
  - After mvalid=0, writes retire in order 7, 8, 9 on consecutive cycles.
- Empty queue, mvalid=0, lvalid=1 with lrd=3, ldata=0xAB → next cycle wwreg=1, wrd=3, wbd=0xAB; lq_count stays 0.
- Fill queue to 2, assert clrn=0 asynchronously mid-cycle → immediately wwreg=0, lq_count=0, pend_mask=0, lready=0; no stale write after release.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback formatter with a small FIFO that merges long-latency results.
// Optional statistics counters (stat_wb, stat_lblock) are built when WB_STATS_EN is defined.
module writeback_stage #(
  parameter int XLEN     = 64,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            mvalid,
  input  logic            mwreg,
  input  logic [4:0]      mrd,
  input  logic [1:0]      msel,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] mmem,
  input  logic [2:0]      mfunct3,
  input  logic [2:0]      maddr_lo,
  input  logic [XLEN-1:0] mpc4,
  input  logic            lvalid,
  output logic            lready,
  input  logic [4:0]      lrd,
  input  logic [XLEN-1:0] ldata,
  output logic [4:0]      wrd,
  output logic [XLEN-1:0] wbd,
  output logic            wwreg,
  output logic [31:0]     pend_mask,
`ifdef WB_STATS_EN
  output logic [1:0]      lq_count,
  output logic [31:0]     stat_wb,
  output logic [31:0]     stat_lblock
`else
  output logic [1:0]      lq_count
`endif
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  typedef enum logic [1:0] {
    SRC_MEM    = 2'b00,
    SRC_QUEUE  = 2'b01,
    SRC_BYPASS = 2'b10,
    SRC_NONE   = 2'b11
  } wsrc_e;

  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_word;
  logic [XLEN-1:0]     load_val;
  logic [XLEN-1:0]     m_result;

  logic [4:0]          q_rd   [LQ_DEPTH];
  logic [XLEN-1:0]     q_data [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] q_vld;
  logic [LQ_DEPTH-1:0] push_mask;
  logic [LQ_DEPTH-1:0] pop_mask;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic                q_empty;
  logic                do_push;
  logic                do_pop;
  wsrc_e               wsrc;

  logic                w_valid;
  logic                w_write;
  logic [4:0]          w_rd;
  logic [XLEN-1:0]     w_data;
  logic [31:0]         pend;

  // Unused low offset bits simply fall out of the part-select bases.
  always_comb begin
    ld_byte = mmem[{maddr_lo, 3'b000} +: 8];
    ld_half = mmem[{maddr_lo[2:1], 4'b0000} +: 16];
    ld_word = mmem[{maddr_lo[2], 5'b00000} +: 32];
    case (mfunct3)
      3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  load_val = {{(XLEN-32){ld_word[31]}}, ld_word};
      3'b011:  load_val = mmem;
      3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
      3'b110:  load_val = {{(XLEN-32){1'b0}}, ld_word};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    case (msel)
      2'b01:   m_result = load_val;
      2'b10:   m_result = mpc4;
      default: m_result = malu;
    endcase
  end

  assign q_empty = (count == '0);
  assign lready  = clrn & (count < CW'(LQ_DEPTH));

  // MEM always wins; the queue head drains before a fresh long result may bypass it.
  always_comb begin
    wsrc      = SRC_NONE;
    do_pop    = 1'b0;
    push_mask = '0;
    pop_mask  = '0;
    if (mvalid) begin
      wsrc = SRC_MEM;
    end else if (!q_empty) begin
      wsrc   = SRC_QUEUE;
      do_pop = 1'b1;
    end else if (lvalid) begin
      wsrc = SRC_BYPASS;
    end
    do_push = lvalid & lready & (wsrc != SRC_BYPASS);
    if (do_push) push_mask[tail] = 1'b1;
    if (do_pop)  pop_mask[head]  = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      q_vld <= (q_vld | push_mask) & ~pop_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      q_rd[tail]   <= lrd;
      q_data[tail] <= ldata;
    end
  end

  // On a bubble only the valid bit drops; destination and data are held.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_valid <= 1'b0;
      w_write <= 1'b0;
      w_rd    <= '0;
      w_data  <= '0;
    end else begin
      case (wsrc)
        SRC_MEM: begin
          w_valid <= 1'b1;
          w_write <= mwreg;
          w_rd    <= mrd;
          w_data  <= m_result;
        end
        SRC_QUEUE: begin
          w_valid <= 1'b1;
          w_write <= 1'b1;
          w_rd    <= q_rd[head];
          w_data  <= q_data[head];
        end
        SRC_BYPASS: begin
          w_valid <= 1'b1;
          w_write <= 1'b1;
          w_rd    <= lrd;
          w_data  <= ldata;
        end
        default: w_valid <= 1'b0;
      endcase
    end
  end

  assign wrd      = w_rd;
  assign wbd      = w_data;
  assign wwreg    = w_valid & w_write & (w_rd != 5'd0);
  assign lq_count = 2'(count);

  always_comb begin
    pend = '0;
    if (wwreg) pend[w_rd] = 1'b1;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (q_vld[i]) pend[q_rd[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign pend_mask = pend;

`ifdef WB_STATS_EN
  // stat_lblock counts cycles where a queued long result was held off by MEM.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stat_wb     <= '0;
      stat_lblock <= '0;
    end else begin
      if (wwreg)               stat_wb     <= stat_wb + 32'd1;
      if (!q_empty && mvalid)  stat_lblock <= stat_lblock + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected writebacks are queued when stimulus is driven
// and popped one cycle later when the W register presents them.
module tb_writeback_stage;

  localparam logic [63:0] MEMV = 64'h8877_6655_4433_2211;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mvalid;
  logic        mwreg;
  logic [4:0]  mrd;
  logic [1:0]  msel;
  logic [63:0] malu;
  logic [63:0] mmem;
  logic [2:0]  mfunct3;
  logic [2:0]  maddr_lo;
  logic [63:0] mpc4;
  logic        lvalid;
  logic        lready;
  logic [4:0]  lrd;
  logic [63:0] ldata;
  logic [4:0]  wrd;
  logic [63:0] wbd;
  logic        wwreg;
  logic [31:0] pend_mask;
  logic [1:0]  lq_count;
`ifdef WB_STATS_EN
  logic [31:0] stat_wb;
  logic [31:0] stat_lblock;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] bd;
    bit          full;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  logic [2:0]  ld_f3  [10] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110,
                               3'b011, 3'b101, 3'b001, 3'b000, 3'b111};
  logic [2:0]  ld_off [10] = '{3'd7, 3'd7, 3'd2, 3'd4, 3'd4,
                               3'd5, 3'd6, 3'd3, 3'd0, 3'd1};
  logic [63:0] ld_exp [10] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_0088,
                               64'h0000_0000_0000_4433, 64'hFFFF_FFFF_8877_6655,
                               64'h0000_0000_8877_6655, 64'h8877_6655_4433_2211,
                               64'h0000_0000_0000_8877, 64'h0000_0000_0000_4433,
                               64'h0000_0000_0000_0011, 64'h0000_0000_0000_0000};

  writeback_stage #(.XLEN(64), .LQ_DEPTH(2)) dut (
    .clk(clk),
    .clrn(clrn),
    .mvalid(mvalid),
    .mwreg(mwreg),
    .mrd(mrd),
    .msel(msel),
    .malu(malu),
    .mmem(mmem),
    .mfunct3(mfunct3),
    .maddr_lo(maddr_lo),
    .mpc4(mpc4),
    .lvalid(lvalid),
    .lready(lready),
    .lrd(lrd),
    .ldata(ldata),
    .wrd(wrd),
    .wbd(wbd),
    .wwreg(wwreg),
    .pend_mask(pend_mask),
`ifdef WB_STATS_EN
    .lq_count(lq_count),
    .stat_wb(stat_wb),
    .stat_lblock(stat_lblock)
`else
    .lq_count(lq_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExpect(input logic we, input logic [4:0] rd, input logic [63:0] bd, input bit full);
    wb_exp_t e;
    e.we   = we;
    e.rd   = rd;
    e.bd   = bd;
    e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    wb_exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("[TB] FAIL %s: observed=empty scoreboard expected=pending entry", tag);
    end else begin
      e = exp_q.pop_front();
      checkValue({tag, ".wwreg"}, 64'(wwreg), 64'(e.we));
      if (e.full) begin
        checkValue({tag, ".wrd"}, 64'(wrd), 64'(e.rd));
        checkValue({tag, ".wbd"}, wbd, e.bd);
      end
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic mw, input logic [4:0] rd,
                               input logic [1:0] sel, input logic [63:0] alu,
                               input logic [63:0] mem, input logic [2:0] f3,
                               input logic [2:0] off, input logic [63:0] pc4);
    mvalid   = mv;
    mwreg    = mw;
    mrd      = rd;
    msel     = sel;
    malu     = alu;
    mmem     = mem;
    mfunct3  = f3;
    maddr_lo = off;
    mpc4     = pc4;
  endtask

  task automatic applyLong(input logic lv, input logic [4:0] rd, input logic [63:0] d);
    lvalid = lv;
    lrd    = rd;
    ldata  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyLong(0, 0, 0);
    #1 clrn = 1'b0;
    #12;
    checkValue("rst.wwreg", 64'(wwreg), 0);
    checkValue("rst.wrd", 64'(wrd), 0);
    checkValue("rst.wbd", wbd, 0);
    checkValue("rst.lq_count", 64'(lq_count), 0);
    checkValue("rst.pend_mask", 64'(pend_mask), 0);
    checkValue("rst.lready", 64'(lready), 0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    checkValue("rel.lready", 64'(lready), 1);
    tick();

    applyStimulus(1, 1, 5'd5, 2'b00, 64'h1234, 0, 0, 0, 0);
    pushExpect(1, 5'd5, 64'h1234, 1);
    tick();
    checkOutput("alu_rd5");

    applyStimulus(1, 1, 5'd0, 2'b00, 64'h55, 0, 0, 0, 0);
    pushExpect(0, 5'd0, 64'h55, 1);
    tick();
    checkOutput("alu_rd0");
    checkValue("rd0.pend_mask", 64'(pend_mask), 0);

    applyStimulus(1, 0, 5'd6, 2'b00, 64'h66, 0, 0, 0, 0);
    pushExpect(0, 5'd6, 64'h66, 0);
    tick();
    checkOutput("nowreg");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 5'(10 + i), 2'b01, 64'hDEAD, MEMV, ld_f3[i], ld_off[i], 64'h0);
      pushExpect(1, 5'(10 + i), ld_exp[i], 1);
      tick();
      checkOutput($sformatf("load%0d", i));
    end

    applyStimulus(1, 1, 5'd1, 2'b10, 64'hDEAD, 0, 0, 0, 64'h1004);
    pushExpect(1, 5'd1, 64'h1004, 1);
    tick();
    checkOutput("pc4");

    applyStimulus(1, 1, 5'd2, 2'b11, 64'hBEEF, 0, 0, 0, 64'h1004);
    pushExpect(1, 5'd2, 64'hBEEF, 1);
    tick();
    checkOutput("sel11");

    // Long-latency results arriving while MEM holds the W slot for four cycles.
    applyStimulus(1, 1, 5'd11, 2'b00, 64'h111, 0, 0, 0, 0);
    applyLong(1, 5'd7, 64'h70);
    pushExpect(1, 5'd11, 64'h111, 1);
    tick();
    checkOutput("blkA");
    checkValue("blkA.lq_count", 64'(lq_count), 1);
    checkValue("blkA.lready", 64'(lready), 1);
    checkValue("blkA.pend_mask", 64'(pend_mask), 64'h880);

    applyStimulus(1, 1, 5'd12, 2'b00, 64'h222, 0, 0, 0, 0);
    applyLong(1, 5'd8, 64'h80);
    pushExpect(1, 5'd12, 64'h222, 1);
    tick();
    checkOutput("blkB");
    checkValue("blkB.lq_count", 64'(lq_count), 2);
    checkValue("blkB.lready", 64'(lready), 0);
    checkValue("blkB.pend_mask", 64'(pend_mask), 64'h1180);

    applyStimulus(1, 1, 5'd13, 2'b00, 64'h333, 0, 0, 0, 0);
    applyLong(1, 5'd9, 64'h90);
    pushExpect(1, 5'd13, 64'h333, 1);
    tick();
    checkOutput("blkC");
    checkValue("blkC.lq_count", 64'(lq_count), 2);
    checkValue("blkC.pend_mask", 64'(pend_mask), 64'h2180);

    applyStimulus(1, 1, 5'd14, 2'b00, 64'h444, 0, 0, 0, 0);
    pushExpect(1, 5'd14, 64'h444, 1);
    tick();
    checkOutput("blkD");
    checkValue("blkD.lq_count", 64'(lq_count), 2);
    checkValue("blkD.lready", 64'(lready), 0);
    checkValue("blkD.pend_mask", 64'(pend_mask), 64'h4180);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pushExpect(1, 5'd7, 64'h70, 1);
    tick();
    checkOutput("drain7");
    checkValue("drain7.lq_count", 64'(lq_count), 1);
    checkValue("drain7.lready", 64'(lready), 1);
    checkValue("drain7.pend_mask", 64'(pend_mask), 64'h180);

    pushExpect(1, 5'd8, 64'h80, 1);
    tick();
    checkOutput("drain8");
    checkValue("drain8.lq_count", 64'(lq_count), 1);
    checkValue("drain8.pend_mask", 64'(pend_mask), 64'h300);

    applyLong(0, 0, 0);
    pushExpect(1, 5'd9, 64'h90, 1);
    tick();
    checkOutput("drain9");
    checkValue("drain9.lq_count", 64'(lq_count), 0);
    checkValue("drain9.pend_mask", 64'(pend_mask), 64'h200);

    pushExpect(0, 5'd9, 64'h90, 1);
    tick();
    checkOutput("bubble");
    checkValue("bubble.pend_mask", 64'(pend_mask), 0);

    applyLong(1, 5'd3, 64'hAB);
    pushExpect(1, 5'd3, 64'hAB, 1);
    tick();
    checkOutput("bypass");
    checkValue("bypass.lq_count", 64'(lq_count), 0);
    applyLong(0, 0, 0);

    // Fill the queue, then drop reset in the middle of a cycle.
    applyStimulus(1, 1, 5'd15, 2'b00, 64'hF15, 0, 0, 0, 0);
    applyLong(1, 5'd20, 64'h200);
    pushExpect(1, 5'd15, 64'hF15, 1);
    tick();
    checkOutput("fill1");
    applyStimulus(1, 1, 5'd16, 2'b00, 64'hF16, 0, 0, 0, 0);
    applyLong(1, 5'd21, 64'h210);
    pushExpect(1, 5'd16, 64'hF16, 1);
    tick();
    checkOutput("fill2");
    checkValue("fill2.lq_count", 64'(lq_count), 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyLong(0, 0, 0);
    #2 clrn = 1'b0;
    #1;
    checkValue("midrst.wwreg", 64'(wwreg), 0);
    checkValue("midrst.lq_count", 64'(lq_count), 0);
    checkValue("midrst.pend_mask", 64'(pend_mask), 0);
    checkValue("midrst.lready", 64'(lready), 0);
    tick();
    checkValue("inrst.wwreg", 64'(wwreg), 0);
    #3 clrn = 1'b1;
    pushExpect(0, 5'd0, 64'h0, 1);
    tick();
    checkOutput("post1");
    checkValue("post1.lq_count", 64'(lq_count), 0);
    checkValue("post1.lready", 64'(lready), 1);
    pushExpect(0, 5'd0, 64'h0, 1);
    tick();
    checkOutput("post2");

    applyStimulus(1, 1, 5'd4, 2'b00, 64'h44, 0, 0, 0, 0);
    pushExpect(1, 5'd4, 64'h44, 1);
    tick();
    checkOutput("post_alu");

    checkValue("sb_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
